// File: rtl/vga_dac_pkg.sv
// Shared constants for the VGA DAC CPU port: I/O port offsets,
// FSM state encoding and the DAC state codes returned by 0x3C7.
package vga_dac_pkg;

  // Port offsets on the 2-bit addr bus
  localparam logic [1:0] PORT_PEL_MASK = 2'd0; // 0x3C6
  localparam logic [1:0] PORT_RD_INDEX = 2'd1; // 0x3C7
  localparam logic [1:0] PORT_WR_INDEX = 2'd2; // 0x3C8
  localparam logic [1:0] PORT_DATA     = 2'd3; // 0x3C9

  // Access FSM encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK     = 2'd2;

  // DAC state codes
  localparam logic [1:0] DAC_WRITE_MODE = 2'b00;
  localparam logic [1:0] DAC_READ_MODE  = 2'b11;

  // RGB component sequence: R -> G -> B -> R
  localparam logic [1:0] CYC_R = 2'd0;
  localparam logic [1:0] CYC_G = 2'd1;
  localparam logic [1:0] CYC_B = 2'd2;

endpackage

// File: rtl/vga_dac_ptr.sv
// Palette index/cycle pointer with RGB auto-increment.
// Ports: clk, rst, load, load_value, inc -> index, cycle.
import vga_dac_pkg::*;

module vga_dac_ptr (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       inc,
  output logic [7:0] index,
  output logic [1:0] cycle
);

  always_ff @(posedge clk) begin
    if (rst) begin
      index <= 8'h00;
      cycle <= CYC_R;
    end else if (load) begin
      index <= load_value;
      cycle <= CYC_R;
    end else if (inc) begin
      unique case (cycle)
        CYC_R: cycle <= CYC_G;
        CYC_G: cycle <= CYC_B;
        default: begin
          // B wraps back to R and steps the index (8-bit wrap)
          cycle <= CYC_R;
          index <= index + 8'd1;
        end
      endcase
    end
  end

endmodule

// File: rtl/vga_dac_cpu_port.sv
// CPU-side VGA DAC port: decodes 0x3C6..0x3C9, keeps read/write
// pointers, drives palette write strobe and returns palette reads.
// Ports: stb/we/addr/wdata -> rdata/ack (CPU); pel_mask (pixel path);
//        write/write_* and read_data_*/read_data (palette RAM).
import vga_dac_pkg::*;

module vga_dac_cpu_port (
  input  logic       clk,
  input  logic       rst,
  input  logic       stb,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       ack,
  output logic [7:0] pel_mask,
  output logic       write,
  output logic [1:0] write_data_cycle,
  output logic [7:0] write_data_register,
  output logic [3:0] write_data,
  output logic [1:0] read_data_cycle,
  output logic [7:0] read_data_register,
  input  logic [3:0] read_data
);

  logic [1:0] state;
  logic [1:0] dac_state;
  logic       rd_pend;
  logic       wr_pend;
  logic       accept;
  logic       rd_load;
  logic       wr_load;
  logic       rd_inc;
  logic       wr_inc;
  logic [7:0] reg_rdata;

  assign accept  = (state == ST_IDLE) && stb;
  assign rd_load = accept && we && (addr == PORT_RD_INDEX);
  assign wr_load = accept && we && (addr == PORT_WR_INDEX);

  // Loads happen on acceptance, increments on the ACK edge,
  // so the two can never collide on one pointer.
  assign rd_inc = (state == ST_ACK) && rd_pend;
  assign wr_inc = (state == ST_ACK) && wr_pend;

  always_comb begin
    reg_rdata = 8'h00;
    unique case (addr)
      PORT_PEL_MASK: reg_rdata = pel_mask;
      PORT_RD_INDEX: reg_rdata = {6'b0, dac_state};
      PORT_WR_INDEX: reg_rdata = write_data_register;
      default:       reg_rdata = 8'h00;
    endcase
  end

  vga_dac_ptr u_rd_ptr (
    .clk        (clk),
    .rst        (rst),
    .load       (rd_load),
    .load_value (wdata),
    .inc        (rd_inc),
    .index      (read_data_register),
    .cycle      (read_data_cycle)
  );

  vga_dac_ptr u_wr_ptr (
    .clk        (clk),
    .rst        (rst),
    .load       (wr_load),
    .load_value (wdata),
    .inc        (wr_inc),
    .index      (write_data_register),
    .cycle      (write_data_cycle)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ack        <= 1'b0;
      write      <= 1'b0;
      rdata      <= 8'h00;
      write_data <= 4'h0;
      pel_mask   <= 8'hFF;
      dac_state  <= DAC_WRITE_MODE;
      rd_pend    <= 1'b0;
      wr_pend    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          ack   <= 1'b0;
          write <= 1'b0;
          if (stb) begin
            if (!we && addr == PORT_DATA) begin
              // Palette RAM needs one clock to return data
              state   <= ST_RD_WAIT;
              rd_pend <= 1'b1;
            end else begin
              state <= ST_ACK;
              ack   <= 1'b1;
              if (we) begin
                unique case (addr)
                  PORT_PEL_MASK: pel_mask <= wdata;
                  PORT_RD_INDEX: dac_state <= DAC_READ_MODE;
                  PORT_WR_INDEX: dac_state <= DAC_WRITE_MODE;
                  default: begin
                    write      <= 1'b1;
                    write_data <= wdata[5:2];
                    wr_pend    <= 1'b1;
                  end
                endcase
              end else begin
                rdata <= reg_rdata;
              end
            end
          end
        end
        ST_RD_WAIT: begin
          rdata <= {2'b00, read_data, 2'b00};
          ack   <= 1'b1;
          state <= ST_ACK;
        end
        ST_ACK: begin
          ack     <= 1'b0;
          write   <= 1'b0;
          rd_pend <= 1'b0;
          wr_pend <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          ack     <= 1'b0;
          write   <= 1'b0;
          rd_pend <= 1'b0;
          wr_pend <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_dac_cpu_port.sv
// Directed bench for vga_dac_cpu_port with a small palette RAM model
// (one-clock read latency) attached to the palette-side ports.
module tb_vga_dac_cpu_port;

  logic       clk = 1'b0;
  logic       rst;
  logic       stb;
  logic       we;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ack;
  logic [7:0] pel_mask;
  logic       write;
  logic [1:0] write_data_cycle;
  logic [7:0] write_data_register;
  logic [3:0] write_data;
  logic [1:0] read_data_cycle;
  logic [7:0] read_data_register;
  logic [3:0] read_data;

  int total = 0;
  int passed = 0;

  logic [3:0] pal [0:255][0:3];
  logic       pl_en = 1'b0;
  logic [7:0] pl_idx = 8'h00;
  logic [1:0] pl_cyc = 2'd0;
  logic [3:0] pl_val = 4'h0;

  always #5 clk = ~clk;

  vga_dac_cpu_port dut (
    .clk                 (clk),
    .rst                 (rst),
    .stb                 (stb),
    .we                  (we),
    .addr                (addr),
    .wdata               (wdata),
    .rdata               (rdata),
    .ack                 (ack),
    .pel_mask            (pel_mask),
    .write               (write),
    .write_data_cycle    (write_data_cycle),
    .write_data_register (write_data_register),
    .write_data          (write_data),
    .read_data_cycle     (read_data_cycle),
    .read_data_register  (read_data_register),
    .read_data           (read_data)
  );

  always @(posedge clk) begin
    if (pl_en) pal[pl_idx][pl_cyc] <= pl_val;
    else if (write) pal[write_data_register][write_data_cycle] <= write_data;
    read_data <= pal[read_data_register][read_data_cycle];
  end

  task automatic preload(input logic [7:0] i, input logic [1:0] c,
                         input logic [3:0] v);
    pl_en = 1'b1; pl_idx = i; pl_cyc = c; pl_val = v;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // One CPU access; returns rdata at ack, edges from stb to ack,
  // and the palette write seen (if any). Returns in IDLE.
  task automatic access(input logic w, input logic [1:0] a,
                        input logic [7:0] d, output logic [7:0] rd,
                        output int lat, output logic ws,
                        output logic [1:0] wc, output logic [7:0] wr,
                        output logic [3:0] wv);
    stb = 1'b1; we = w; addr = a; wdata = d;
    lat = 0; ws = 1'b0; wc = 2'd0; wr = 8'h00; wv = 4'h0;
    rd = 8'h00;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      lat++;
      if (write) begin
        ws = 1'b1; wc = write_data_cycle;
        wr = write_data_register; wv = write_data;
      end
      if (ack) break;
    end
    rd = rdata;
    stb = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [7:0] r;
  int         l;
  logic       ws;
  logic [1:0] wc;
  logic [7:0] wr;
  logic [3:0] wv;

  task automatic test_reset();
    rst = 1'b1; stb = 1'b0; we = 1'b0; addr = 2'd0; wdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ack !== 1'b0) $display("FAIL rst_ack got %b want 0", ack); else passed++;
    total++; if (write !== 1'b0) $display("FAIL rst_write got %b want 0", write); else passed++;
    total++; if (rdata !== 8'h00) $display("FAIL rst_rdata got %h want 00", rdata); else passed++;
    total++; if (write_data !== 4'h0) $display("FAIL rst_wdat got %h want 0", write_data); else passed++;
    total++; if (pel_mask !== 8'hFF) $display("FAIL rst_mask got %h want ff", pel_mask); else passed++;
    total++; if ({write_data_register, write_data_cycle, read_data_register, read_data_cycle} !== 20'h0)
      $display("FAIL rst_ptrs got %h/%0d %h/%0d want 0", write_data_register, write_data_cycle,
               read_data_register, read_data_cycle);
    else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
    access(1'b0, 2'd0, 8'h00, r, l, ws, wc, wr, wv);
    total++; if (r !== 8'hFF || l != 1) $display("FAIL rd_3c6 got %h lat %0d want ff lat 1", r, l); else passed++;
    access(1'b0, 2'd1, 8'h00, r, l, ws, wc, wr, wv);
    total++; if (r !== 8'h00 || l != 1) $display("FAIL rd_3c7 got %h lat %0d want 00 lat 1", r, l); else passed++;
  endtask

  task automatic test_write_seq();
    logic [7:0] din [3];
    logic [3:0] dexp [3];
    din = '{8'h3C, 8'h20, 8'h04};
    dexp = '{4'hF, 4'h8, 4'h1};
    access(1'b1, 2'd2, 8'h10, r, l, ws, wc, wr, wv);
    for (int i = 0; i < 3; i++) begin
      access(1'b1, 2'd3, din[i], r, l, ws, wc, wr, wv);
      total++;
      if (!ws || wc !== 2'(i) || wr !== 8'h10 || wv !== dexp[i] || l != 1)
        $display("FAIL wr_pulse%0d got w=%b c=%0d r=%h d=%h lat=%0d want 1 %0d 10 %h 1",
                 i, ws, wc, wr, wv, l, i, dexp[i]);
      else passed++;
    end
    total++;
    if (write_data_register !== 8'h11 || write_data_cycle !== 2'd0)
      $display("FAIL wr_after got %h/%0d want 11/0", write_data_register, write_data_cycle);
    else passed++;
    total++;
    if (read_data_register !== 8'h00 || read_data_cycle !== 2'd0)
      $display("FAIL wr_rdptr got %h/%0d want 00/0", read_data_register, read_data_cycle);
    else passed++;
  endtask

  task automatic test_write_wrap();
    access(1'b1, 2'd2, 8'hFF, r, l, ws, wc, wr, wv);
    for (int i = 0; i < 3; i++)
      access(1'b1, 2'd3, 8'h00, r, l, ws, wc, wr, wv);
    total++;
    if (write_data_register !== 8'h00 || write_data_cycle !== 2'd0 || wr !== 8'hFF || wc !== 2'd2)
      $display("FAIL wr_wrap got %h/%0d last %h/%0d want 00/0 last ff/2",
               write_data_register, write_data_cycle, wr, wc);
    else passed++;
  endtask

  task automatic test_read_seq();
    logic [7:0] rexp [3];
    rexp = '{8'h3C, 8'h20, 8'h04};
    preload(8'h10, 2'd0, 4'hF);
    preload(8'h10, 2'd1, 4'h8);
    preload(8'h10, 2'd2, 4'h1);
    access(1'b1, 2'd1, 8'h10, r, l, ws, wc, wr, wv);
    for (int i = 0; i < 3; i++) begin
      access(1'b0, 2'd3, 8'h00, r, l, ws, wc, wr, wv);
      total++;
      if (r !== rexp[i] || l != 2 || ws)
        $display("FAIL rd_data%0d got %h lat %0d w=%b want %h lat 2 w=0", i, r, l, ws, rexp[i]);
      else passed++;
    end
    access(1'b0, 2'd1, 8'h00, r, l, ws, wc, wr, wv);
    total++; if (r !== 8'h03) $display("FAIL rd_state got %h want 03", r); else passed++;
    total++;
    if (read_data_register !== 8'h11 || read_data_cycle !== 2'd0)
      $display("FAIL rd_after got %h/%0d want 11/0", read_data_register, read_data_cycle);
    else passed++;
  endtask

  task automatic test_interleave();
    preload(8'h30, 2'd0, 4'h5);
    preload(8'h30, 2'd1, 4'hA);
    access(1'b1, 2'd1, 8'h30, r, l, ws, wc, wr, wv);
    access(1'b1, 2'd2, 8'h20, r, l, ws, wc, wr, wv);
    access(1'b1, 2'd3, 8'h3C, r, l, ws, wc, wr, wv);
    total++;
    if (write_data_cycle !== 2'd1 || read_data_cycle !== 2'd0 || wr !== 8'h20)
      $display("FAIL il_wr got wc=%0d rc=%0d reg=%h want 1 0 20",
               write_data_cycle, read_data_cycle, wr);
    else passed++;
    access(1'b0, 2'd3, 8'h00, r, l, ws, wc, wr, wv);
    total++;
    if (r !== 8'h14 || read_data_cycle !== 2'd1 || write_data_cycle !== 2'd1)
      $display("FAIL il_rd0 got %h rc=%0d wc=%0d want 14 1 1", r, read_data_cycle, write_data_cycle);
    else passed++;
    access(1'b0, 2'd3, 8'h00, r, l, ws, wc, wr, wv);
    total++;
    if (r !== 8'h28 || read_data_cycle !== 2'd2 || write_data_cycle !== 2'd1)
      $display("FAIL il_rd1 got %h rc=%0d wc=%0d want 28 2 1", r, read_data_cycle, write_data_cycle);
    else passed++;
    access(1'b0, 2'd2, 8'h00, r, l, ws, wc, wr, wv);
    total++; if (r !== 8'h20) $display("FAIL il_3c8 got %h want 20", r); else passed++;
    access(1'b0, 2'd1, 8'h00, r, l, ws, wc, wr, wv);
    total++; if (r !== 8'h00) $display("FAIL il_state got %h want 00", r); else passed++;
    access(1'b1, 2'd0, 8'h5A, r, l, ws, wc, wr, wv);
    total++; if (ws || pel_mask !== 8'h5A) $display("FAIL il_mask got %h w=%b want 5a w=0", pel_mask, ws); else passed++;
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    stb = 1'b1; we = 1'b0; addr = 2'd3;
    @(posedge clk); #1;
    rst = 1'b1; stb = 1'b0;
    @(posedge clk); #1;
    seen = ack | write;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      seen = seen | ack | write;
    end
    total++; if (seen !== 1'b0) $display("FAIL mid_ack got ack/write %b want 0", seen); else passed++;
    total++; if (pel_mask !== 8'hFF) $display("FAIL mid_mask got %h want ff", pel_mask); else passed++;
    total++;
    if (read_data_register !== 8'h00 || read_data_cycle !== 2'd0 || write_data_register !== 8'h00)
      $display("FAIL mid_ptrs got %h/%0d %h want 00/0 00",
               read_data_register, read_data_cycle, write_data_register);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_write_seq();
    test_write_wrap();
    test_read_seq();
    test_interleave();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vga_dac_cpu_port.md
# vga_dac_cpu_port

CPU-side controller for the VGA DAC palette, sitting directly upstream of the DAC register file. It decodes the four DAC I/O ports (0x3C6 PEL mask, 0x3C7 read index / DAC state, 0x3C8 write index, 0x3C9 data). It maintains the read and write index/cycle pointers with RGB auto-increment and produces the write strobe and addresses the palette RAM consumes. It also returns palette read data to the CPU through a stb/ack handshake.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- stb  in  1  CPU access request; held until ack
- we  in  1  1 = write, 0 = read; valid with stb
- addr  in  2  0 = 0x3C6, 1 = 0x3C7, 2 = 0x3C8, 3 = 0x3C9
- wdata  in  8  CPU write data
- rdata  out  8  CPU read data, valid while ack = 1
- ack  out  1  one-cycle access acknowledge
- pel_mask  out  8  PEL mask register, to the pixel path
- write  out  1  one-cycle palette write strobe
- write_data_cycle  out  2  0 = R, 1 = G, 2 = B
- write_data_register  out  8  palette write index
- write_data  out  4  palette write value = wdata[5:2]
- read_data_cycle  out  2  0 = R, 1 = G, 2 = B
- read_data_register  out  8  palette read index
- read_data  in  4  palette read value; one-clock latency from read_data_cycle/read_data_register

## Operation
- FSM states: IDLE, RD_WAIT, ACK. Encoding is held in the shared package.
- IDLE with stb=1:
  - Data read (addr=3, we=0): go to RD_WAIT.
  - Any other access: perform it and go to ACK.
- RD_WAIT: rdata <= {2'b00, read_data, 2'b00}. Go to ACK.
- ACK: ack=1 for exactly this cycle. Post-increment the pointer used by a 0x3C9 access, then return to IDLE. stb is ignored in ACK.
- Write to 0x3C6: pel_mask <= wdata.
- Write to 0x3C7: read_data_register <= wdata, read_data_cycle <= 0, dac_state <= 2'b11.
- Write to 0x3C8: write_data_register <= wdata, write_data_cycle <= 0, dac_state <= 2'b00.
- Write to 0x3C9: write=1 and write_data <= wdata[5:2] for the ACK cycle. The write uses the pre-increment cycle and register values.
- Reads by port:
  - 0x3C6 returns pel_mask.
  - 0x3C7 returns {6'b0, dac_state}.
  - 0x3C8 returns write_data_register.
  - 0x3C9 returns palette data.
- Increment rule, applied separately to the read and write pointers:
  - cycle 0 → 1 → 2 → 0.
  - On 2 → 0, register += 1, wrapping 8 bits (255 → 0).
  - Cycle value 3 is never produced.
- Read and write pointers are independent. A 0x3C9 read never moves the write pointer, and a 0x3C9 write never moves the read pointer.

## Timing
- Reset values:
  - ack=0, write=0, rdata=0, write_data=0.
  - pel_mask=0xFF, dac_state=0.
  - All cycles and registers = 0.
  - State = IDLE.
- stb sampled in IDLE at edge N:
  - Non-data-read accesses: ack (and write, for 0x3C9 writes) high in cycle N+1.
  - Data reads: ack high in cycle N+2.
- All outputs are registered. read_data_cycle/read_data_register are stable from acceptance through RD_WAIT, so the DAC's one-clock read latency is covered.
- Pointer increment becomes visible the cycle after ack.
- Throughput: one access per 2 cycles, or 3 cycles for a data read.
- Reset mid-access aborts with no ack and no write. Pointers return to reset values.
- An index write immediately followed by a data access uses the new index, because the increment and index updates never coincide.

## Structure
- Shared package (vga_dac_pkg): port offset constants, FSM state encoding, and the DAC state codes (DAC_WRITE_MODE=2'b00, DAC_READ_MODE=2'b11).
- One sub-module, vga_dac_ptr, instantiated twice (read and write pointers):
  - Holds an 8-bit index and a 2-bit cycle.
  - Inputs: load, load value, inc.
  - Implements reset, load (cycle 0) and the wrap rule.

## Test plan
- Reset, then read 0x3C6 and 0x3C7 → rdata 0xFF, then 0x00. All pointers are 0.
- Write 0x3C8=0x10, then 0x3C9 with 0x3C, 0x20, 0x04 → write pulses at (cycle 0, reg 0x10, data 0xF), (1, 0x10, 0x8), (2, 0x10, 0x1). After that, write_data_register=0x11 and write_data_cycle=0.
- Write 0x3C8=0xFF, then three 0x3C9 writes → write_data_register wraps to 0x00.
- Write 0x3C7=0x10 with the DAC model returning preloaded 0xF/0x8/0x1, then three 0x3C9 reads → rdata 0x3C, 0x20, 0x04, each acked 2 cycles after stb. 0x3C7 then reads 0x03 and read_data_register=0x11.
- Interleave 0x3C9 reads and writes after setting both indices → each pointer advances only on its own access type. 0x3C8 reads back the write index.
- Assert rst in the RD_WAIT cycle → no ack, write stays 0, pel_mask returns to 0xFF.
